truth_table_sequencer: RTL and testbench

- Self-checking stimulus controller for a 4-input combinational lab function (inputs A, B, C, D; output Out).
- On a start pulse, it walks all 16 input combinations, waits a settle interval, samples Out, and builds a 16-bit captured truth table.
- It compares the capture against a 16-bit expected table and reports done and pass. Sits between board switches/buttons (or a bench) and the combinational unit.

---
 rtl/tt_seq_pkg.sv | 15 +
 rtl/tt_settle_counter.sv | 27 ++
 rtl/truth_table_sequencer.sv | 167 ++++++++++++++++
 tb/tb_truth_table_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table sequencer.
package tt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 16;
  localparam int unsigned IDX_W       = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd15;

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-interval counter: clears on load, counts up on en, flags SETTLE_CYCLES-1.
module tt_settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 16 inputs of a 4-input unit, captures its truth table and grades it.
// Optional first-failure reporting is enabled with `define TT_SEQ_FIRST_FAIL_EN.
module truth_table_sequencer
  import tt_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] tt_capture,
  output logic [4:0]  mismatch_cnt
`ifdef TT_SEQ_FIRST_FAIL_EN
  ,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_vld
`endif
);

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx, idx_next;
  logic [15:0]       exp_q, exp_next;
  logic [15:0]       cap_next;
  logic [4:0]        mcnt_next;
  logic              busy_next, done_next, pass_next;
  logic              cnt_load, cnt_en, cnt_tc;
  logic              miss;
`ifdef TT_SEQ_FIRST_FAIL_EN
  logic [3:0]        ff_idx_next;
  logic              ff_vld_next;
`endif

  tt_settle_counter #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  assign miss = (dut_out != exp_q[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    exp_next   = exp_q;
    cap_next   = tt_capture;
    mcnt_next  = mismatch_cnt;
    busy_next  = busy;
    done_next  = 1'b0;
    pass_next  = pass;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
`ifdef TT_SEQ_FIRST_FAIL_EN
    ff_idx_next = first_fail_idx;
    ff_vld_next = first_fail_vld;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          exp_next   = expected;
          idx_next   = '0;
          cnt_load   = 1'b1;
          cap_next   = '0;
          mcnt_next  = '0;
          pass_next  = 1'b0;
          busy_next  = 1'b1;
          state_next = SETTLE;
`ifdef TT_SEQ_FIRST_FAIL_EN
          ff_idx_next = '0;
          ff_vld_next = 1'b0;
`endif
        end
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        cap_next[idx] = dut_out;
        if (miss) begin
          mcnt_next = mismatch_cnt + 5'd1;
        end
`ifdef TT_SEQ_FIRST_FAIL_EN
        if (miss && !first_fail_vld) begin
          ff_idx_next = idx;
          ff_vld_next = 1'b1;
        end
`endif
        if (idx == LAST_IDX) begin
          // done/pass are registered on entry to DONE so they coincide with that state
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (mcnt_next == '0);
        end else begin
          idx_next   = idx + 4'd1;
          cnt_load   = 1'b1;
          state_next = SETTLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      exp_q        <= '0;
      tt_capture   <= '0;
      mismatch_cnt <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
`ifdef TT_SEQ_FIRST_FAIL_EN
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
`endif
    end else begin
      idx          <= idx_next;
      exp_q        <= exp_next;
      tt_capture   <= cap_next;
      mismatch_cnt <= mcnt_next;
      busy         <= busy_next;
      done         <= done_next;
      pass         <= pass_next;
`ifdef TT_SEQ_FIRST_FAIL_EN
      first_fail_idx <= ff_idx_next;
      first_fail_vld <= ff_vld_next;
`endif
    end
  end

  assign A = idx[3];
  assign B = idx[2];
  assign C = idx[1];
  assign D = idx[0];

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: two instances (SETTLE_CYCLES 2 and 1) driving a modelled unit.
module tb_truth_table_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       start_v;
  logic [1:0][15:0] exp_v;
  logic [1:0][15:0] func_tt;
  logic [1:0]       a_v, b_v, c_v, d_v, dout_v, busy_v, done_v, pass_v;
  logic [1:0][15:0] cap_v;
  logic [1:0][4:0]  mcnt_v;
`ifdef TT_SEQ_FIRST_FAIL_EN
  logic [1:0][3:0]  ffi_v;
  logic [1:0]       ffv_v;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  assign dout_v[0] = func_tt[0][{a_v[0], b_v[0], c_v[0], d_v[0]}];
  assign dout_v[1] = func_tt[1][{a_v[1], b_v[1], c_v[1], d_v[1]}];

  truth_table_sequencer #(.SETTLE_CYCLES(S0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
    .A(a_v[0]), .B(b_v[0]), .C(c_v[0]), .D(d_v[0]), .dut_out(dout_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .tt_capture(cap_v[0]), .mismatch_cnt(mcnt_v[0])
`ifdef TT_SEQ_FIRST_FAIL_EN
    , .first_fail_idx(ffi_v[0]), .first_fail_vld(ffv_v[0])
`endif
  );

  truth_table_sequencer #(.SETTLE_CYCLES(S1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
    .A(a_v[1]), .B(b_v[1]), .C(c_v[1]), .D(d_v[1]), .dut_out(dout_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .tt_capture(cap_v[1]), .mismatch_cnt(mcnt_v[1])
`ifdef TT_SEQ_FIRST_FAIL_EN
    , .first_fail_idx(ffi_v[1]), .first_fail_vld(ffv_v[1])
`endif
  );

  typedef struct {
    int          s;
    logic [15:0] func;
    logic [15:0] exp;
    int          ex1;
    int          ex2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic int settle_of(input int s);
    return (s == 0) ? S0 : S1;
  endfunction

  function automatic logic [3:0] vec(input int s);
    return {a_v[s], b_v[s], c_v[s], d_v[s]};
  endfunction

  task automatic check_reset_state(input int s, input string tag);
    check({tag, "_abcd"}, 32'(vec(s)), 32'd0);
    check({tag, "_busy"}, 32'(busy_v[s]), 32'd0);
    check({tag, "_done"}, 32'(done_v[s]), 32'd0);
    check({tag, "_pass"}, 32'(pass_v[s]), 32'd0);
    check({tag, "_cap"}, 32'(cap_v[s]), 32'd0);
    check({tag, "_mcnt"}, 32'(mcnt_v[s]), 32'd0);
`ifdef TT_SEQ_FIRST_FAIL_EN
    check({tag, "_ffi"}, 32'(ffi_v[s]), 32'd0);
    check({tag, "_ffv"}, 32'(ffv_v[s]), 32'd0);
`endif
  endtask

  // Reference: a combinational unit yields its own table; grading is a popcount of the difference.
  task automatic check_results(input int s, input logic [15:0] func, input logic [15:0] exp,
                               input string tag);
    logic [15:0] diff;
    int          first;
    diff  = func ^ exp;
    first = -1;
    for (int i = 15; i >= 0; i--) if (diff[i]) first = i;
    check({tag, "_cap"}, 32'(cap_v[s]), 32'(func));
    check({tag, "_mcnt"}, 32'(mcnt_v[s]), 32'($countones(diff)));
    check({tag, "_pass"}, 32'(pass_v[s]), 32'(diff == 16'h0));
`ifdef TT_SEQ_FIRST_FAIL_EN
    check({tag, "_ffv"}, 32'(ffv_v[s]), 32'(first >= 0));
    check({tag, "_ffi"}, 32'(ffi_v[s]), (first >= 0) ? 32'(first) : 32'd0);
`endif
  endtask

  task automatic sweep(input int s, input logic [15:0] func, input logic [15:0] exp,
                       input int ex1, input int ex2, input string tag);
    int per, lat, k, done_at, busy_cnt, vec_err;
    per      = settle_of(s) + 1;
    lat      = 16 * per + 1;
    done_at  = -1;
    busy_cnt = 0;
    vec_err  = 0;
    @(negedge clk);
    func_tt[s] = func;
    exp_v[s]   = exp;
    start_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    exp_v[s]   = 16'($urandom);
    k = 1;
    while (done_at < 0 && k <= lat + 20) begin
      if (done_v[s]) begin
        done_at = k;
      end else begin
        if (busy_v[s]) busy_cnt++;
        if (vec(s) != 4'((k - 1) / per)) vec_err++;
        start_v[s] = (k == ex1 || k == ex2);
        @(negedge clk);
        k++;
      end
    end
    start_v[s] = 1'b0;
    check({tag, "_latency"}, 32'(done_at), 32'(lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(16 * per));
    check({tag, "_vec_seq"}, 32'(vec_err), 32'd0);
    check({tag, "_busy_at_done"}, 32'(busy_v[s]), 32'd0);
    check({tag, "_abcd_at_done"}, 32'(vec(s)), 32'hF);
    check_results(s, func, exp, tag);
    @(negedge clk);
    check({tag, "_done_single"}, 32'(done_v[s]), 32'd0);
    check({tag, "_busy_after"}, 32'(busy_v[s]), 32'd0);
    check({tag, "_abcd_hold"}, 32'(vec(s)), 32'hF);
    check({tag, "_pass_hold"}, 32'(pass_v[s]), 32'((func ^ exp) == 16'h0));
  endtask

  task automatic wait_done(input int s, input int limit, input string tag);
    int k;
    k = 0;
    while (!done_v[s] && k < limit) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_seen"}, 32'(done_v[s]), 32'd1);
  endtask

  vec_t tbl[6];

  initial begin
    int          seen, dcount;
    logic [15:0] f, e;
    int          s;

    rst_n   = 1'b0;
    start_v = '0;
    exp_v   = '0;
    func_tt = '0;
    #3;
    check_reset_state(0, "por0");
    check_reset_state(1, "por1");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0] = '{0, 16'h6996, 16'h6996, 0, 0};
    tbl[1] = '{0, 16'h6996, 16'h6997, 0, 0};
    tbl[2] = '{0, 16'h0000, 16'hFFFF, 0, 0};
    tbl[3] = '{0, 16'h6996, 16'h6996, 5, 30};
    tbl[4] = '{1, 16'h8000, 16'h8000, 0, 0};
    tbl[5] = '{1, 16'h6996, 16'h1234, 3, 20};
    for (int i = 0; i < 6; i++) begin
      sweep(tbl[i].s, tbl[i].func, tbl[i].exp, tbl[i].ex1, tbl[i].ex2, $sformatf("tbl%0d", i));
    end

    // abort mid-sweep with reset at idx 7
    @(negedge clk);
    func_tt[0] = 16'h6996;
    exp_v[0]   = 16'h6996;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 100 && seen == 0; k++) begin
      if (vec(0) == 4'd7) seen = 1;
      else @(negedge clk);
    end
    check("rst_reach_idx7", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state(0, "abort");
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dcount += done_v[0];
    end
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      dcount += done_v[0];
    end
    check("abort_no_done", 32'(dcount), 32'd0);
    check_reset_state(0, "abort_idle");
    sweep(0, 16'h6996, 16'h6996, 0, 0, "post_abort");

    // start held high: back-to-back sweeps
    @(negedge clk);
    func_tt[0] = 16'hA5C3;
    exp_v[0]   = 16'hA5C2;
    start_v[0] = 1'b1;
    @(negedge clk);
    wait_done(0, 60, "held1_done");
    check("held1_pass", 32'(pass_v[0]), 32'd0);
    exp_v[0] = 16'hA5C3;
    @(negedge clk);
    check("held_idle_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    check("held_restart_busy", 32'(busy_v[0]), 32'd1);
    check("held_restart_pass", 32'(pass_v[0]), 32'd0);
    check("held_restart_mcnt", 32'(mcnt_v[0]), 32'd0);
    start_v[0] = 1'b0;
    wait_done(0, 60, "held2_done");
    check_results(0, 16'hA5C3, 16'hA5C3, "held2");

    // randomized units and golden tables
    for (int i = 0; i < 10; i++) begin
      s = int'($urandom_range(0, 1));
      f = 16'($urandom);
      e = ($urandom_range(0, 2) == 0) ? f : (f ^ 16'($urandom));
      sweep(s, f, e, 0, 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
